// File: rtl/ysyx_23060124_ifu.sv
// Instruction fetch unit: one AXI4-Lite read at a time, with redirect handling that
// lets an in-flight transaction finish and then drops its response.
module ysyx_23060124_ifu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] ifu_araddr,
    output logic        ifu_arvalid,
    input  logic        ifu_arready,
    input  logic [31:0] ifu_rdata,
    input  logic [1:0]  ifu_rresp,
    input  logic        ifu_rvalid,
    output logic        ifu_rready,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_ins,
    output logic [31:0] o_pc,
    output logic        o_fetch_err,
    output logic        o_valid,
    input  logic        i_ready
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_OUT} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_araddr, w_araddr_nxt;
    logic        r_kill, w_kill_nxt;
    logic        w_capture;
    logic [31:0] r_ins, r_opc;
    logic        r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_kill_nxt  = r_kill;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_AR;
            S_AR: if (ifu_arready) w_state_nxt = S_R;
            S_R: begin
                if (ifu_rvalid) begin
                    if (r_kill || i_redirect_valid) begin
                        w_state_nxt = S_AR;
                        w_kill_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_OUT;
                        w_capture   = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (i_redirect_valid || i_ready) begin
                    w_state_nxt = S_AR;
                    w_pc_nxt    = r_pc + 32'd4;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Redirect overrides pc; a transaction already on the bus is marked for discard.
        if (i_redirect_valid) begin
            w_pc_nxt = {i_redirect_pc[31:2], 2'b00};
            if (r_state == S_AR || (r_state == S_R && !ifu_rvalid))
                w_kill_nxt = 1'b1;
        end
        // araddr is only reloaded on entry to AR, so it stays put while arvalid waits.
        w_araddr_nxt = (w_state_nxt == S_AR && r_state != S_AR) ? w_pc_nxt : r_araddr;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_araddr <= RESET_PC;
            r_kill   <= 1'b0;
            r_ins    <= '0;
            r_opc    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_araddr <= w_araddr_nxt;
            r_kill   <= w_kill_nxt;
            if (w_capture) begin
                r_ins <= ifu_rdata;
                r_opc <= r_pc;
                r_err <= (ifu_rresp != 2'b00);
            end
        end
    end

    assign ifu_araddr  = r_araddr;
    assign ifu_arvalid = (r_state == S_AR);
    assign ifu_rready  = (r_state == S_R);
    assign o_valid     = (r_state == S_OUT);
    assign o_ins       = r_ins;
    assign o_pc        = r_opc;
    assign o_fetch_err = r_err;

endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
// Bench for the fetch unit: AXI4-Lite slave model plus a delivery-order reference
// (next expected pc advances by 4 on accept, jumps to the target on redirect).
module tb_ysyx_23060124_ifu;

    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready = 1'b0;
    logic [31:0] ifu_rdata = '0;
    logic [1:0]  ifu_rresp = '0;
    logic        ifu_rvalid = 1'b0;
    logic        ifu_rready;
    logic        i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic [31:0] o_ins, o_pc;
    logic        o_fetch_err, o_valid;
    logic        i_ready = 1'b0;

    ysyx_23060124_ifu #(.RESET_PC(RST_PC)) dut (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
        .o_ins(o_ins), .o_pc(o_pc), .o_fetch_err(o_fetch_err), .o_valid(o_valid), .i_ready(i_ready)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    // slave model state and knobs
    bit          slv_busy = 1'b0;
    logic [31:0] slv_addr = '0;
    int          slv_cnt = 0;
    int          lat_min = 0, lat_max = 0;
    bit          arr_rand = 1'b0;
    bit          const_data = 1'b0;
    bit          err_hash = 1'b0;
    logic [31:0] err_addr = 32'h0000_0001;
    bit          last_rhs = 1'b0, last_arhs = 1'b0;
    logic [31:0] last_araddr = '0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return const_data ? 32'h0000_0013 : (a ^ 32'hC001_D00D);
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return (a == err_addr) || (err_hash && a[4:2] == 3'b101);
    endfunction

    task automatic tick();
        bit arhs, rhs, rst_n;
        logic [31:0] a;
        arhs  = ifu_arvalid && ifu_arready;
        rhs   = ifu_rvalid && ifu_rready;
        rst_n = reset;
        a     = ifu_araddr;
        @(posedge clock);
        #1;
        last_rhs    = rhs && rst_n;
        last_arhs   = arhs && rst_n;
        last_araddr = a;
        if (!rst_n) begin
            slv_busy = 1'b0;
        end else begin
            if (rhs) slv_busy = 1'b0;
            if (arhs) begin
                slv_busy = 1'b1;
                slv_addr = a;
                slv_cnt  = int'($urandom_range(lat_max, lat_min));
            end
        end
        ifu_rvalid = 1'b0;
        ifu_rdata  = '0;
        ifu_rresp  = '0;
        if (slv_busy) begin
            if (slv_cnt == 0) begin
                ifu_rvalid = 1'b1;
                ifu_rdata  = mem(slv_addr);
                ifu_rresp  = is_err(slv_addr) ? 2'b10 : 2'b00;
            end else begin
                slv_cnt--;
            end
        end
        ifu_arready = !slv_busy && (!arr_rand || $urandom_range(1, 0) == 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        i_ready = 1'b0;
        i_redirect_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (o_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] t;
        lat_min = 1; lat_max = 2; arr_rand = 1'b1; i_ready = 1'b1;
        reset = 1'b1;
        repeat (7) tick();
        t = $urandom;
        reset = 1'b0; i_redirect_valid = 1'b1; i_redirect_pc = t;
        repeat (2) begin
            tick();
            n_checks++; if (ifu_arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b want 0", ifu_arvalid); end
            n_checks++; if (ifu_rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready: got %b want 0", ifu_rready); end
            n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_valid); end
            n_checks++; if ({o_ins, o_pc, o_fetch_err} !== 65'd0) begin n_fail++; $display("FAIL rst_outs: got ins %h pc %h err %b want zeros", o_ins, o_pc, o_fetch_err); end
        end
        i_redirect_valid = 1'b0; i_ready = 1'b0; reset = 1'b1;
        tick();
        n_checks++; if (ifu_arvalid !== 1'b1 || ifu_araddr !== RST_PC) begin n_fail++; $display("FAIL rst_first_ar: got v %b a %h want 1 %h", ifu_arvalid, ifu_araddr, RST_PC); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_pc, next_ar;
        int ndel, last_cyc, period;
        bit prev_v;
        do_reset();
        lat_min = 0; lat_max = 0; arr_rand = 1'b0; const_data = 1'b1; i_ready = 1'b1;
        exp_pc = RST_PC; next_ar = RST_PC; ndel = 0; prev_v = 1'b0; last_cyc = 0; period = 0;
        for (int cyc = 0; cyc < 60 && ndel < 4; cyc++) begin
            tick();
            if (last_arhs) begin
                n_checks++; if (last_araddr !== next_ar) begin n_fail++; $display("FAIL basic_araddr: got %h want %h", last_araddr, next_ar); end
                next_ar += 32'd4;
            end
            if (o_valid) begin
                n_checks++; if (o_pc !== exp_pc || o_ins !== 32'h13 || o_fetch_err !== 1'b0) begin n_fail++; $display("FAIL basic_deliver: got pc %h ins %h err %b want %h 00000013 0", o_pc, o_ins, o_fetch_err, exp_pc); end
                n_checks++; if (prev_v || !last_rhs) begin n_fail++; $display("FAIL basic_latency: got prev_valid %b prev_rhs %b want 0 1", prev_v, last_rhs); end
                if (ndel == 1) period = cyc - last_cyc;
                if (ndel >= 2) begin
                    n_checks++; if (cyc - last_cyc !== period) begin n_fail++; $display("FAIL basic_period: got %0d want %0d", cyc - last_cyc, period); end
                end
                last_cyc = cyc; exp_pc += 32'd4; ndel++;
            end
            prev_v = o_valid;
        end
        n_checks++; if (ndel != 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", ndel); end
        const_data = 1'b0; i_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] s_pc, s_ins;
        bit ok;
        do_reset();
        lat_min = 0; lat_max = 2; arr_rand = 1'b1; i_ready = 1'b0;
        wait_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got no o_valid want o_valid"); end
        s_pc = o_pc; s_ins = o_ins;
        n_checks++; if (s_pc !== RST_PC || s_ins !== mem(RST_PC)) begin n_fail++; $display("FAIL stall_first: got %h %h want %h %h", s_pc, s_ins, RST_PC, mem(RST_PC)); end
        repeat (5) begin
            tick();
            n_checks++; if (o_valid !== 1'b1 || o_pc !== s_pc || o_ins !== s_ins || ifu_arvalid !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold: got v %b pc %h ins %h arv %b want 1 %h %h 0", o_valid, o_pc, o_ins, ifu_arvalid, s_pc, s_ins);
            end
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        n_checks++; if (o_valid !== 1'b0 || ifu_arvalid !== 1'b1 || ifu_araddr !== s_pc + 32'd4) begin
            n_fail++; $display("FAIL stall_next: got v %b arv %b a %h want 0 1 %h", o_valid, ifu_arvalid, ifu_araddr, s_pc + 32'd4);
        end
    endtask

    task automatic test_redirect_r();
        bit ok, first_ar;
        do_reset();
        lat_min = 3; lat_max = 3; arr_rand = 1'b0; i_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = ifu_rready; end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL redir_r_wait: got no rready want rready"); end
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h8000_0102; i_ready = 1'b0;
        tick();
        i_redirect_valid = 1'b0;
        ok = 1'b0; first_ar = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (last_arhs && first_ar) begin
                first_ar = 1'b0;
                n_checks++; if (last_araddr !== 32'h8000_0100) begin n_fail++; $display("FAIL redir_r_araddr: got %h want 80000100", last_araddr); end
            end
            if (o_valid) begin
                ok = 1'b1;
                n_checks++; if (o_pc !== 32'h8000_0100 || o_ins !== mem(32'h8000_0100)) begin
                    n_fail++; $display("FAIL redir_r_deliver: got %h %h want 80000100 %h", o_pc, o_ins, mem(32'h8000_0100));
                end
            end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL redir_r_timeout: got no delivery want one"); end
    endtask

    task automatic test_redirect_out();
        bit ok;
        logic [31:0] t;
        do_reset();
        lat_min = 0; lat_max = 0; arr_rand = 1'b0; i_ready = 1'b0;
        wait_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL redir_out_wait: got no o_valid want o_valid"); end
        i_ready = 1'b1; i_redirect_valid = 1'b1; i_redirect_pc = 32'h3000_0040;
        tick();
        i_ready = 1'b0; i_redirect_valid = 1'b0;
        n_checks++; if (o_valid !== 1'b0 || ifu_arvalid !== 1'b1 || ifu_araddr !== 32'h3000_0040) begin
            n_fail++; $display("FAIL redir_out_ready: got v %b arv %b a %h want 0 1 30000040", o_valid, ifu_arvalid, ifu_araddr);
        end
        wait_valid(ok);
        n_checks++; if (!ok || o_pc !== 32'h3000_0040) begin n_fail++; $display("FAIL redir_out_pc: got ok %b pc %h want 1 30000040", ok, o_pc); end
        t = $urandom;
        i_redirect_valid = 1'b1; i_redirect_pc = t;
        tick();
        i_redirect_valid = 1'b0;
        n_checks++; if (o_valid !== 1'b0 || ifu_arvalid !== 1'b1 || ifu_araddr !== {t[31:2], 2'b00}) begin
            n_fail++; $display("FAIL redir_out_noready: got v %b arv %b a %h want 0 1 %h", o_valid, ifu_arvalid, ifu_araddr, {t[31:2], 2'b00});
        end
    endtask

    task automatic test_err_wrap();
        bit ok;
        do_reset();
        lat_min = 0; lat_max = 1; arr_rand = 1'b1; err_addr = RST_PC; i_ready = 1'b0;
        wait_valid(ok);
        n_checks++; if (!ok || o_pc !== RST_PC || o_fetch_err !== 1'b1) begin n_fail++; $display("FAIL err_first: got ok %b pc %h err %b want 1 %h 1", ok, o_pc, o_fetch_err, RST_PC); end
        i_ready = 1'b1; tick(); i_ready = 1'b0;
        wait_valid(ok);
        n_checks++; if (!ok || o_pc !== RST_PC + 32'd4 || o_fetch_err !== 1'b0) begin n_fail++; $display("FAIL err_next: got ok %b pc %h err %b want 1 %h 0", ok, o_pc, o_fetch_err, RST_PC + 32'd4); end
        err_addr = 32'h0000_0001;
        i_redirect_valid = 1'b1; i_redirect_pc = 32'hFFFF_FFFF;
        tick();
        i_redirect_valid = 1'b0;
        wait_valid(ok);
        n_checks++; if (!ok || o_pc !== 32'hFFFF_FFFC || o_ins !== mem(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_deliver: got ok %b pc %h ins %h want 1 fffffffc %h", ok, o_pc, o_ins, mem(32'hFFFF_FFFC)); end
        i_ready = 1'b1; tick(); i_ready = 1'b0;
        n_checks++; if (ifu_arvalid !== 1'b1 || ifu_araddr !== 32'h0) begin n_fail++; $display("FAIL wrap_araddr: got arv %b a %h want 1 00000000", ifu_arvalid, ifu_araddr); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, pend_addr, h_pc, h_ins, rpc;
        bit pend, hold, h_err, prev_v;
        int ndel;
        do_reset();
        lat_min = 0; lat_max = 3; arr_rand = 1'b1; err_hash = 1'b1;
        exp_pc = RST_PC; pend = 1'b0; hold = 1'b0; prev_v = 1'b0; ndel = 0;
        h_pc = '0; h_ins = '0; h_err = 1'b0; pend_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (pend) begin
                n_checks++; if (ifu_arvalid !== 1'b1 || ifu_araddr !== pend_addr) begin n_fail++; $display("FAIL rnd_next_ar: got arv %b a %h want 1 %h", ifu_arvalid, ifu_araddr, pend_addr); end
            end
            if (hold) begin
                n_checks++; if (o_valid !== 1'b1 || o_pc !== h_pc || o_ins !== h_ins || o_fetch_err !== h_err) begin
                    n_fail++; $display("FAIL rnd_hold: got v %b pc %h ins %h err %b want 1 %h %h %b", o_valid, o_pc, o_ins, o_fetch_err, h_pc, h_ins, h_err);
                end
            end
            if (o_valid) begin
                n_checks++; if (o_pc !== exp_pc || o_ins !== mem(exp_pc) || o_fetch_err !== is_err(exp_pc)) begin
                    n_fail++; $display("FAIL rnd_deliver: got pc %h ins %h err %b want %h %h %b", o_pc, o_ins, o_fetch_err, exp_pc, mem(exp_pc), is_err(exp_pc));
                end
                if (!prev_v) begin
                    n_checks++; if (!last_rhs) begin n_fail++; $display("FAIL rnd_latency: got prev_rhs 0 want 1"); end
                end
            end
            n_checks++; if (slv_busy && ifu_arvalid) begin n_fail++; $display("FAIL rnd_outstanding: got arvalid 1 with read pending want 0"); end
            i_ready = ($urandom_range(2, 0) != 0);
            i_redirect_valid = ($urandom_range(7, 0) == 0);
            rpc = $urandom;
            i_redirect_pc = rpc;
            rpc = {rpc[31:2], 2'b00};
            hold = o_valid && !i_ready && !i_redirect_valid;
            h_pc = o_pc; h_ins = o_ins; h_err = o_fetch_err;
            pend = o_valid && (i_ready || i_redirect_valid);
            pend_addr = i_redirect_valid ? rpc : o_pc + 32'd4;
            if (o_valid && i_ready && !i_redirect_valid) ndel++;
            if (i_redirect_valid) exp_pc = rpc;
            else if (o_valid && i_ready) exp_pc += 32'd4;
            prev_v = o_valid;
        end
        i_redirect_valid = 1'b0; i_ready = 1'b0; err_hash = 1'b0;
        n_checks++; if (ndel < 50) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries want >= 50", ndel); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_basic();
        test_stall();
        test_redirect_r();
        test_redirect_out();
        test_err_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
